la_capture: RTL and testbench

LA_CAPTURE -- requirements
Module: la_capture

---
 rtl/la_pkg.sv | 48 ++++
 rtl/la_capture_ram.sv | 45 ++++
 rtl/la_capture.sv | 242 ++++++++++++++++++++++++
 tb/tb_la_capture.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// ----------------------------------------------------------------------------
// la_pkg
// Shared types and constants for the logic-analyser capture block.
//   trig_mode_e : how the trigger probe is qualified (level high/low, edges)
//   la_state_e  : capture controller states
//   MODE_*      : numeric trigger-mode encodings as seen on trig_mode_i
//   trigMatch() : evaluates one trigger condition from the current and
//                 previous probe values
// ----------------------------------------------------------------------------
package la_pkg;

   localparam logic [1:0] MODE_LEVEL_HIGH = 2'd0;
   localparam logic [1:0] MODE_LEVEL_LOW  = 2'd1;
   localparam logic [1:0] MODE_RISING     = 2'd2;
   localparam logic [1:0] MODE_FALLING    = 2'd3;

   typedef enum logic [1:0] {
      TRIG_LEVEL_HIGH = MODE_LEVEL_HIGH,
      TRIG_LEVEL_LOW  = MODE_LEVEL_LOW,
      TRIG_RISING     = MODE_RISING,
      TRIG_FALLING    = MODE_FALLING
   } trig_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_WAIT,
      ST_POST,
      ST_READ
   } la_state_e;

   // Edge modes look at the registered previous probe value, level modes
   // only at the current one.
   function automatic logic trigMatch(input trig_mode_e mode,
                                      input logic       cur,
                                      input logic       prev);
      logic m;
      case (mode)
         TRIG_LEVEL_HIGH: m = cur;
         TRIG_LEVEL_LOW:  m = ~cur;
         TRIG_RISING:     m = cur & ~prev;
         TRIG_FALLING:    m = ~cur & prev;
         default:         m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/la_capture_ram.sv
// ----------------------------------------------------------------------------
// la_capture_ram
// Simple dual-port sample buffer, DEPTH x DATA_W, one write port and one
// read port with a registered (1-cycle) read. The read register only
// updates when re_i is high, so a fetched word is held until the next read.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i     read request; rdata_o valid the cycle after re_i
//   rdata_o          registered read data
// ----------------------------------------------------------------------------
module la_capture_ram #(
   parameter  int DATA_W = 18,
   parameter  int DEPTH  = 256,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Sample write; contents are deliberately never cleared.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   // Registered read, held while no new read is requested.
   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/la_capture.sv
// ----------------------------------------------------------------------------
// la_capture
// Single-clock logic-analyser capture engine. After an arm pulse it records
// pretrig samples, waits for a trigger, fills the rest of the circular
// buffer and then streams DEPTH words, oldest first, over a valid/ready
// interface.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   data_i                 probe vector
//   trig_i, trig_mode_i    trigger probe and mode (latched on arm)
//   pretrig_i              pre-trigger sample count (latched on arm)
//   arm_i                  start / restart pulse
//   trig_cnt_i             (LA_TRIG_COUNT_EN only) fire on Nth match, 0 = 1
//   armed_o, triggered_o, done_o   status flags
//   rd_valid_o, rd_ready_i, rd_data_o, rd_last_o   readout stream
// Optional feature macro: LA_TRIG_COUNT_EN
// ----------------------------------------------------------------------------
module la_capture
   import la_pkg::*;
#(
   parameter  int DATA_W = 18,
   parameter  int DEPTH  = 256,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              trig_i,
   input  logic [1:0]        trig_mode_i,
   input  logic [AW-1:0]     pretrig_i,
   input  logic              arm_i,
`ifdef LA_TRIG_COUNT_EN
   input  logic [7:0]        trig_cnt_i,
`endif
   output logic              armed_o,
   output logic              triggered_o,
   output logic              done_o,
   output logic              rd_valid_o,
   input  logic              rd_ready_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_last_o
);

   localparam logic [AW:0] NUM_WORDS = (AW+1)'(DEPTH);
   localparam logic [AW:0] LAST_WORD = NUM_WORDS - (AW+1)'(1);

   la_state_e         state_q, state_d;
   trig_mode_e        mode_q, mode_d;
   logic [AW-1:0]     pretrig_q, pretrig_d;
   logic [AW-1:0]     wrPtr_q, wrPtr_d;
   logic [AW-1:0]     trigPtr_q, trigPtr_d;
   logic              trigPrev_q;
   logic              triggered_q, triggered_d;
   logic [AW:0]       rdCnt_q, rdCnt_d;
   logic              ramVld_q, ramVld_d;
   logic              ramLast_q, ramLast_d;
   logic              rdValid_q, rdValid_d;
   logic              rdLast_q, rdLast_d;
   logic [DATA_W-1:0] rdData_q, rdData_d;

   logic              capturing, wrEn, waitMatch, fire;
   logic [AW-1:0]     startPtr, lastPostPtr, ramAddr;
   logic              inRead, xfer, finalXfer, loadOut, slotFree, issue;
   logic [DATA_W-1:0] ramRdata;

   assign capturing   = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
   assign wrEn        = capturing && !arm_i;
   assign waitMatch   = (state_q == ST_WAIT) && !arm_i && trigMatch(mode_q, trig_i, trigPrev_q);
   assign startPtr    = trigPtr_q - pretrig_q;
   // POST ends on the slot just before the oldest pre-trigger sample.
   assign lastPostPtr = startPtr - AW'(1);

   // Readout pipeline: RAM output acts as a one-word prefetch stage in front
   // of the output register, so a stalled word never has to be re-read.
   assign inRead    = (state_q == ST_READ);
   assign xfer      = rdValid_q && rd_ready_i;
   assign finalXfer = inRead && xfer && rdLast_q;
   assign loadOut   = inRead && ramVld_q && (!rdValid_q || rd_ready_i);
   assign slotFree  = !ramVld_q || loadOut;
   assign issue     = inRead && slotFree && (rdCnt_q < NUM_WORDS);
   assign ramAddr   = startPtr + rdCnt_q[AW-1:0];

`ifdef LA_TRIG_COUNT_EN
   logic [7:0] trigCnt_q, matchCnt_q, trigTarget;

   assign trigTarget = (trigCnt_q == 8'd0) ? 8'd1 : trigCnt_q;
   assign fire       = waitMatch && ((matchCnt_q + 8'd1) >= trigTarget);

   // Match counter for the Nth-match trigger; restarted by every arm.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         trigCnt_q  <= 8'd0;
         matchCnt_q <= 8'd0;
      end else if (arm_i) begin
         trigCnt_q  <= trig_cnt_i;
         matchCnt_q <= 8'd0;
      end else if (waitMatch) begin
         matchCnt_q <= matchCnt_q + 8'd1;
      end
   end
`else
   assign fire = waitMatch;
`endif

   la_capture_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (wrEn),
      .waddr_i (wrPtr_q),
      .wdata_i (data_i),
      .re_i    (issue),
      .raddr_i (ramAddr),
      .rdata_o (ramRdata)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state. Arm wins over everything except reset; a zero pre-trigger
   // count skips PRE and a full pre-trigger window skips POST.
   always_comb begin
      state_d = state_q;
      if (arm_i) begin
         state_d = (pretrig_i == '0) ? ST_WAIT : ST_PRE;
      end else begin
         case (state_q)
            ST_PRE:  if (wrPtr_q == pretrig_q - AW'(1)) state_d = ST_WAIT;
            ST_WAIT: if (fire) state_d = (&pretrig_q) ? ST_READ : ST_POST;
            ST_POST: if (wrPtr_q == lastPostPtr) state_d = ST_READ;
            ST_READ: if (finalXfer) state_d = ST_IDLE;
            default: ;
         endcase
      end
   end

   // Status outputs decoded from the state.
   always_comb begin
      armed_o = capturing;
      done_o  = inRead;
   end

   // Datapath next-state: write pointer, trigger bookkeeping and readout.
   always_comb begin
      mode_d      = mode_q;
      pretrig_d   = pretrig_q;
      wrPtr_d     = wrEn ? (wrPtr_q + AW'(1)) : wrPtr_q;
      trigPtr_d   = trigPtr_q;
      triggered_d = triggered_q;
      rdCnt_d     = rdCnt_q;
      ramVld_d    = ramVld_q;
      ramLast_d   = ramLast_q;
      rdValid_d   = rdValid_q;
      rdLast_d    = rdLast_q;
      rdData_d    = rdData_q;
      if (arm_i) begin
         mode_d      = trig_mode_e'(trig_mode_i);
         pretrig_d   = pretrig_i;
         wrPtr_d     = '0;
         triggered_d = 1'b0;
         rdCnt_d     = '0;
         ramVld_d    = 1'b0;
         ramLast_d   = 1'b0;
         rdValid_d   = 1'b0;
         rdLast_d    = 1'b0;
      end else begin
         if (fire) begin
            trigPtr_d   = wrPtr_q;
            triggered_d = 1'b1;
         end
         if (issue) begin
            rdCnt_d   = rdCnt_q + (AW+1)'(1);
            ramLast_d = (rdCnt_q == LAST_WORD);
         end
         ramVld_d = issue || (ramVld_q && !loadOut);
         if (loadOut) begin
            rdData_d  = ramRdata;
            rdValid_d = 1'b1;
            rdLast_d  = ramLast_q;
         end else if (xfer) begin
            rdValid_d = 1'b0;
            rdLast_d  = 1'b0;
         end
         if (finalXfer) begin
            rdCnt_d  = '0;
            ramVld_d = 1'b0;
         end
      end
   end

   // Datapath registers; reset clears everything except the sample buffer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q      <= TRIG_LEVEL_HIGH;
         pretrig_q   <= '0;
         wrPtr_q     <= '0;
         trigPtr_q   <= '0;
         triggered_q <= 1'b0;
         rdCnt_q     <= '0;
         ramVld_q    <= 1'b0;
         ramLast_q   <= 1'b0;
         rdValid_q   <= 1'b0;
         rdLast_q    <= 1'b0;
         rdData_q    <= '0;
      end else begin
         mode_q      <= mode_d;
         pretrig_q   <= pretrig_d;
         wrPtr_q     <= wrPtr_d;
         trigPtr_q   <= trigPtr_d;
         triggered_q <= triggered_d;
         rdCnt_q     <= rdCnt_d;
         ramVld_q    <= ramVld_d;
         ramLast_q   <= ramLast_d;
         rdValid_q   <= rdValid_d;
         rdLast_q    <= rdLast_d;
         rdData_q    <= rdData_d;
      end
   end

   // Previous trigger value for edge detection, tracked every cycle so it
   // is freshly loaded on the arm cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         trigPrev_q <= 1'b0;
      end else begin
         trigPrev_q <= trig_i;
      end
   end

   assign triggered_o = triggered_q;
   assign rd_valid_o  = rdValid_q;
   assign rd_data_o   = rdData_q;
   assign rd_last_o   = rdLast_q;

endmodule

// File: tb/tb_la_capture.sv
// ----------------------------------------------------------------------------
// tb_la_capture
// Directed bench for la_capture with DEPTH=16. data_i carries a running
// sample number, so every expected readout word is simply the trigger
// sample number offset by the pre-trigger count. Expected words are queued
// when the trigger is driven and popped as words leave the stream.
// Optional feature macro: LA_TRIG_COUNT_EN
// ----------------------------------------------------------------------------
module tb_la_capture;
   import la_pkg::*;

   localparam int DATA_W = 18;
   localparam int DEPTH  = 16;
   localparam int AW     = 4;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [DATA_W-1:0] data_i;
   logic              trig_i;
   logic [1:0]        trig_mode_i;
   logic [AW-1:0]     pretrig_i;
   logic              arm_i;
`ifdef LA_TRIG_COUNT_EN
   logic [7:0]        trig_cnt_i;
`endif
   logic              armed_o, triggered_o, done_o;
   logic              rd_valid_o, rd_ready_i, rd_last_o;
   logic [DATA_W-1:0] rd_data_o;

   int                checks = 0;
   int                errors = 0;
   logic [DATA_W-1:0] sb[$];

   la_capture #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .data_i      (data_i),
      .trig_i      (trig_i),
      .trig_mode_i (trig_mode_i),
      .pretrig_i   (pretrig_i),
      .arm_i       (arm_i),
`ifdef LA_TRIG_COUNT_EN
      .trig_cnt_i  (trig_cnt_i),
`endif
      .armed_o     (armed_o),
      .triggered_o (triggered_o),
      .done_o      (done_o),
      .rd_valid_o  (rd_valid_o),
      .rd_ready_i  (rd_ready_i),
      .rd_data_o   (rd_data_o),
      .rd_last_o   (rd_last_o)
   );

   // 100 MHz clock.
   always #5 clk_i = ~clk_i;

   // Hard stop in case the sequence ever wedges.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: wait past the edge, then present the next sample number.
   task automatic step();
      @(posedge clk_i);
      #1;
      data_i = data_i + 18'd1;
   endtask

   // Arm pulse with new mode/pretrig, then scramble the inputs so only the
   // latched copies can produce correct results.
   task automatic applyStimulus(input logic [1:0] mode, input logic [AW-1:0] pre);
      arm_i       = 1'b1;
      trig_mode_i = mode;
      pretrig_i   = pre;
      step();
      arm_i       = 1'b0;
      trig_mode_i = ~mode;
      pretrig_i   = ~pre;
      sb.delete();
   endtask

   task automatic pushWindow(input logic [DATA_W-1:0] first);
      for (int i = 0; i < DEPTH; i++) begin
         sb.push_back(first + DATA_W'(i));
      end
   endtask

   task automatic checkFlags(input string tag, input logic a, input logic t, input logic d, input logic v);
      checkOutput({tag, "_armed"},     32'(armed_o),     32'(a));
      checkOutput({tag, "_triggered"}, 32'(triggered_o), 32'(t));
      checkOutput({tag, "_done"},      32'(done_o),      32'(d));
      checkOutput({tag, "_rd_valid"},  32'(rd_valid_o),  32'(v));
   endtask

   // Drain nWords from the stream, checking order, last flag and stability
   // of a stalled word.
   task automatic readOut(input int nWords, input bit randomReady);
      int                got    = 0;
      int                budget = 0;
      bit                held   = 1'b0;
      logic [DATA_W-1:0] heldData = '0;
      logic              heldLast = 1'b0;
      logic [DATA_W-1:0] expv;
      while (got < nWords && budget < 400) begin
         if (held) begin
            checkOutput("stall_valid", 32'(rd_valid_o), 32'd1);
            checkOutput("stall_data",  32'(rd_data_o),  32'(heldData));
            checkOutput("stall_last",  32'(rd_last_o),  32'(heldLast));
         end
         rd_ready_i = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         held = 1'b0;
         if (rd_valid_o && rd_ready_i) begin
            if (sb.size() == 0) begin
               checkOutput("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
               expv = sb.pop_front();
               checkOutput("rd_data", 32'(rd_data_o), 32'(expv));
               checkOutput("rd_last", 32'(rd_last_o), (sb.size() == 0) ? 32'd1 : 32'd0);
            end
            got++;
         end else if (rd_valid_o) begin
            held     = 1'b1;
            heldData = rd_data_o;
            heldLast = rd_last_o;
         end
         step();
         budget++;
      end
      rd_ready_i = 1'b0;
      checkOutput("readout_count", 32'(got), 32'(nWords));
   endtask

   initial begin
      rst_i       = 1'b1;
      arm_i       = 1'b1;
      data_i      = '0;
      trig_i      = 1'b0;
      trig_mode_i = MODE_LEVEL_HIGH;
      pretrig_i   = '0;
      rd_ready_i  = 1'b1;
`ifdef LA_TRIG_COUNT_EN
      trig_cnt_i  = 8'd0;
`endif
      step();
      step();
      step();
      rst_i      = 1'b0;
      arm_i      = 1'b0;
      rd_ready_i = 1'b0;
      $display("[TB] reset state");
      checkFlags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_rd_data", 32'(rd_data_o), 32'd0);
      checkOutput("reset_rd_last", 32'(rd_last_o), 32'd0);

      // Rising edge, pretrig 4, trigger on sample 20 -> words 16..31.
      $display("[TB] rising edge, pretrig 4");
      while (data_i != 18'd10) step();
      applyStimulus(MODE_RISING, 4'd4);
      checkFlags("arm1", 1'b1, 1'b0, 1'b0, 1'b0);
      while (data_i != 18'd20) step();
      trig_i = 1'b1;
      pushWindow(18'd16);
      step();
      checkFlags("trig1", 1'b1, 1'b1, 1'b0, 1'b0);
      readOut(16, 1'b0);
      checkFlags("end1", 1'b0, 1'b1, 1'b0, 1'b0);

      // Level high, no pre-trigger, trigger the cycle after arm; random ready.
      $display("[TB] level high, pretrig 0, random ready");
      trig_i = 1'b0;
      applyStimulus(MODE_LEVEL_HIGH, 4'd0);
      trig_i = 1'b1;
      pushWindow(data_i);
      step();
      trig_i = 1'b0;
      checkFlags("trig2", 1'b1, 1'b1, 1'b0, 1'b0);
      readOut(16, 1'b1);
      checkFlags("end2", 1'b0, 1'b1, 1'b0, 1'b0);

      // Falling edge, pretrig 15: edges during PRE ignored, POST skipped.
      $display("[TB] falling edge, pretrig 15");
      trig_i = 1'b1;
      step();
      applyStimulus(MODE_FALLING, 4'd15);
      for (int i = 0; i < 15; i++) begin
         trig_i = (i % 2 == 0);
         step();
      end
      checkFlags("pre3", 1'b1, 1'b0, 1'b0, 1'b0);
      trig_i = 1'b1;
      step();
      step();
      trig_i = 1'b0;
      pushWindow(data_i - 18'd15);
      step();
      checkFlags("trig3", 1'b0, 1'b1, 1'b1, 1'b0);
      readOut(16, 1'b0);

      // Arm mid-POST, then arm in WAIT with trigger already high.
      $display("[TB] abort in POST and READ");
      trig_i = 1'b0;
      applyStimulus(MODE_LEVEL_HIGH, 4'd2);
      step();
      step();
      step();
      trig_i = 1'b1;
      pushWindow(data_i - 18'd2);
      step();
      trig_i = 1'b0;
      step();
      step();
      step();
      step();
      applyStimulus(MODE_LEVEL_HIGH, 4'd0);
      checkFlags("abortpost", 1'b1, 1'b0, 1'b0, 1'b0);
      trig_i = 1'b1;
      applyStimulus(MODE_LEVEL_HIGH, 4'd0);
      trig_i = 1'b0;
      step();
      step();
      checkFlags("armmatch", 1'b1, 1'b0, 1'b0, 1'b0);
      trig_i = 1'b1;
      pushWindow(data_i);
      step();
      trig_i = 1'b0;
      readOut(5, 1'b1);
      applyStimulus(MODE_RISING, 4'd3);
      checkFlags("abortread", 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      step();
      step();
      step();
      step();
      trig_i = 1'b1;
      pushWindow(data_i - 18'd3);
      step();
      readOut(16, 1'b1);
      checkFlags("end4", 1'b0, 1'b1, 1'b0, 1'b0);

      // Reset in the middle of a readout, with a transfer pending.
      $display("[TB] reset during READ");
      applyStimulus(MODE_LEVEL_LOW, 4'd1);
      step();
      step();
      trig_i = 1'b0;
      pushWindow(data_i - 18'd1);
      step();
      trig_i = 1'b1;
      readOut(3, 1'b0);
      rst_i      = 1'b1;
      rd_ready_i = 1'b1;
      step();
      rst_i      = 1'b0;
      rd_ready_i = 1'b0;
      checkFlags("rstread", 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("rstread_rd_data", 32'(rd_data_o), 32'd0);
      checkOutput("rstread_rd_last", 32'(rd_last_o), 32'd0);

`ifdef LA_TRIG_COUNT_EN
      // Nth-match trigger: third pulse fires, then count 0 behaves as 1.
      $display("[TB] trigger count");
      trig_i     = 1'b0;
      trig_cnt_i = 8'd3;
      applyStimulus(MODE_LEVEL_HIGH, 4'd0);
      trig_cnt_i = 8'd0;
      for (int p = 1; p <= 3; p++) begin
         step();
         step();
         trig_i = 1'b1;
         if (p == 3) pushWindow(data_i);
         step();
         trig_i = 1'b0;
         checkOutput("cnt3_triggered", 32'(triggered_o), (p == 3) ? 32'd1 : 32'd0);
      end
      readOut(16, 1'b0);
      trig_cnt_i = 8'd0;
      applyStimulus(MODE_LEVEL_HIGH, 4'd0);
      trig_cnt_i = 8'd5;
      step();
      step();
      trig_i = 1'b1;
      pushWindow(data_i);
      step();
      trig_i = 1'b0;
      checkOutput("cnt0_triggered", 32'(triggered_o), 32'd1);
      readOut(16, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
